ppg_column_adder_acc: RTL and testbench

//  Stage directly downstream of the multiplier partial-product generator: consumes its 15 bit-column buses (pp14..pp0).

---
 rtl/ppg_column_adder_acc.sv | 167 ++++++++++++++++
 tb/tb_ppg_column_adder_acc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppg_column_adder_acc.sv
// ppg_column_adder_acc
//   Column adder and group accumulator placed after the partial-product
//   generator. Each of the 15 column buses pp14..pp0 holds the bits of that
//   column for 9 lanes, arranged as 9-bit slices. Every column is popcounted.
//   The counts are then shift-added together with the correction constant CORR,
//   which gives the signed 19-bit sum of the 9 lane products. These window sums
//   are accumulated over a channel group that ends with in_last.
//
//   Optional feature: define ACC_SAT_EN to make the accumulator add saturate.
//   When it is not defined, the accumulator wraps modulo 2^ACC_W.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   pp buses and in_last carry a beat
//   in_ready   block accepts a beat (low while a result is stalled)
//   in_last    beat closes the channel group
//   pp14..pp0  column bit buses (9 bits per slice)
//   out_valid  out_data/out_cnt hold a finished group
//   out_ready  consumer takes the result
//   out_data   signed group sum, ACC_W bits
//   out_cnt    beats in the group, saturating at 2^CNT_W-1
module ppg_column_adder_acc #(
  parameter int          ACC_W = 24,
  parameter int          CNT_W = 8,
  parameter logic [18:0] CORR  = 19'h4E800
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [8:0]              pp14,
  input  logic [8:0]              pp13,
  input  logic [17:0]             pp12,
  input  logic [17:0]             pp11,
  input  logic [35:0]             pp10,
  input  logic [35:0]             pp9,
  input  logic [35:0]             pp8,
  input  logic [35:0]             pp7,
  input  logic [44:0]             pp6,
  input  logic [26:0]             pp5,
  input  logic [35:0]             pp4,
  input  logic [17:0]             pp3,
  input  logic [26:0]             pp2,
  input  logic [8:0]              pp1,
  input  logic [17:0]             pp0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_cnt
);

  function automatic logic [5:0] popcnt(input logic [44:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 45; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  // This result is exact modulo 2^19, and every 3x3 window of 8x8 products
  // fits in 19 signed bits.
  function automatic logic signed [18:0] window_sum(input logic [14:0][5:0] c);
    logic [18:0] s;
    s = CORR;
    for (int k = 0; k < 15; k++) s = s + (19'(c[k]) << k);
    return $signed(s);
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] x,
                                                      input logic signed [ACC_W-1:0] y);
`ifdef ACC_SAT_EN
    logic [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
`else
    return x + y;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic                    stall;
  logic [14:0][5:0]        col_cnt;
  logic                    vld_p1, last_p1;
  logic [14:0][5:0]        cnt_p1;
  logic                    vld_p2, last_p2;
  logic signed [18:0]      wsum_p2;
  logic signed [ACC_W-1:0] wsum_ext;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]        beat_cnt, cnt_nxt;
  logic                    first;

  // A result that the consumer has not taken freezes the whole pipe.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    col_cnt[14] = popcnt({36'd0, pp14});
    col_cnt[13] = popcnt({36'd0, pp13});
    col_cnt[12] = popcnt({27'd0, pp12});
    col_cnt[11] = popcnt({27'd0, pp11});
    col_cnt[10] = popcnt({9'd0, pp10});
    col_cnt[9]  = popcnt({9'd0, pp9});
    col_cnt[8]  = popcnt({9'd0, pp8});
    col_cnt[7]  = popcnt({9'd0, pp7});
    col_cnt[6]  = popcnt(pp6);
    col_cnt[5]  = popcnt({18'd0, pp5});
    col_cnt[4]  = popcnt({9'd0, pp4});
    col_cnt[3]  = popcnt({27'd0, pp3});
    col_cnt[2]  = popcnt({18'd0, pp2});
    col_cnt[1]  = popcnt({36'd0, pp1});
    col_cnt[0]  = popcnt({27'd0, pp0});
  end

  assign wsum_ext = ACC_W'(wsum_p2);

  always_comb begin
    acc_nxt = acc_add(first ? '0 : acc, wsum_ext);
    cnt_nxt = first ? CNT_W'(1) : cnt_inc(beat_cnt);
  end

  // Data registers of stage 1 (column counts) and stage 2 (window sum).
  // These are not reset, because the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      cnt_p1  <= col_cnt;
      last_p1 <= in_last;
      wsum_p2 <= window_sum(cnt_p1);
      last_p2 <= last_p1;
    end
  end

  // Valid pipeline and stage 3 (group accumulate / result register).
  // Any result that is not held by a stall is overwritten or dropped on this
  // edge, so out_valid simply follows a last beat arriving in stage 3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
      first     <= 1'b1;
    end else if (!stall) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2 & last_p2;
      if (vld_p2) begin
        acc      <= acc_nxt;
        beat_cnt <= cnt_nxt;
        first    <= last_p2;
        if (last_p2) begin
          out_data <= acc_nxt;
          out_cnt  <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppg_column_adder_acc.sv
module tb_ppg_column_adder_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, in_last, out_ready, in_valid20;
  logic in_ready, out_valid, in_ready20, out_valid20;
  logic signed [23:0] out_data;
  logic [7:0]         out_cnt;
  logic signed [19:0] out_data20;
  logic [7:0]         out_cnt20;

  logic [44:0] bus [15];
  logic [8:0]  pp14, pp13, pp1;
  logic [17:0] pp12, pp11, pp3, pp0;
  logic [35:0] pp10, pp9, pp8, pp7, pp4;
  logic [44:0] pp6;
  logic [26:0] pp5, pp2;

  assign pp14 = bus[14][8:0];
  assign pp13 = bus[13][8:0];
  assign pp12 = bus[12][17:0];
  assign pp11 = bus[11][17:0];
  assign pp10 = bus[10][35:0];
  assign pp9  = bus[9][35:0];
  assign pp8  = bus[8][35:0];
  assign pp7  = bus[7][35:0];
  assign pp6  = bus[6];
  assign pp5  = bus[5][26:0];
  assign pp4  = bus[4][35:0];
  assign pp3  = bus[3][17:0];
  assign pp2  = bus[2][26:0];
  assign pp1  = bus[1][8:0];
  assign pp0  = bus[0][17:0];

  ppg_column_adder_acc #(.ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .pp14(pp14), .pp13(pp13), .pp12(pp12), .pp11(pp11), .pp10(pp10), .pp9(pp9), .pp8(pp8),
    .pp7(pp7), .pp6(pp6), .pp5(pp5), .pp4(pp4), .pp3(pp3), .pp2(pp2), .pp1(pp1), .pp0(pp0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt));

  ppg_column_adder_acc #(.ACC_W(20), .CNT_W(8)) dut20 (
    .clk(clk), .reset(reset), .in_valid(in_valid20), .in_ready(in_ready20), .in_last(in_last),
    .pp14(pp14), .pp13(pp13), .pp12(pp12), .pp11(pp11), .pp10(pp10), .pp9(pp9), .pp8(pp8),
    .pp7(pp7), .pp6(pp6), .pp5(pp5), .pp4(pp4), .pp3(pp3), .pp2(pp2), .pp1(pp1), .pp0(pp0),
    .out_valid(out_valid20), .out_ready(1'b1), .out_data(out_data20), .out_cnt(out_cnt20));

  int ntests = 0;
  int nfail  = 0;

  // Per-lane column bits of the radix-4 Booth generator: lb[col][slice].
  logic [4:0] lb [15];
  int         nf [15];

  function automatic void put(input int col, input logic bv);
    lb[col][nf[col]] = bv;
    nf[col] = nf[col] + 1;
  endfunction

  // Radix-4 Booth partial products of a*b, with all 9 lanes identical.
  // Row i holds the 9-bit value (neg ? ~(m*a) : m*a) at offset 2i, and its neg
  // bit sits at column 2i. Row 0 sign-extends as s,s,~s in columns 8..10.
  // Rows 1..3 place ~s at column 2i+8. The remaining constant is folded into CORR.
  task automatic set_ab(input int a, input int b);
    logic [7:0] bb;
    logic [8:0] b9, p9;
    logic [2:0] tr;
    logic       ng;
    int         d, pv;
    bb = 8'(b);
    b9 = {bb, 1'b0};
    for (int k = 0; k < 15; k++) begin
      lb[k] = '0;
      nf[k] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      tr = b9[2*i +: 3];
      d  = int'(tr[0]) + int'(tr[1]) - 2 * int'(tr[2]);
      ng = (d < 0);
      pv = ng ? d * a - 1 : d * a;
      p9 = 9'(pv);
      for (int j = 0; j < 8; j++) put(2*i + j, p9[j]);
      if (i == 0) begin
        put(8, p9[8]);
        put(9, p9[8]);
        put(10, ~p9[8]);
      end else begin
        put(2*i + 8, ~p9[8]);
      end
      put(2*i, ng);
    end
    for (int k = 0; k < 15; k++)
      for (int s = 0; s < 5; s++)
        for (int l = 0; l < 9; l++)
          bus[k][s*9 + l] = lb[k][s];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int a, input int b, input logic last);
    set_ab(a, b);
    in_last  = last;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  int q[$];
  int e;

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_valid20 = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    set_ab(0, 0);
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid20", out_valid20, 0);
    reset = 1'b1;
    step();

    // Test 1: a zero product, with latency of exactly two edges.
    beat(0, 0, 1'b1);
    check("t1_vld_n", out_valid, 0);
    step();
    check("t1_vld_n1", out_valid, 0);
    step();
    check("t1_vld_n2", out_valid, 1);
    check("t1_data", out_data, 0);
    check("t1_cnt", out_cnt, 1);
    step();
    check("t1_vld_drop", out_valid, 0);

    // Test 2: two single-beat groups sent back to back.
    beat(3, -5, 1'b1);
    beat(-128, -128, 1'b1);
    step();
    check("t2_vld_a", out_valid, 1);
    check("t2_data_a", out_data, -135);
    check("t2_cnt_a", out_cnt, 1);
    step();
    check("t2_vld_b", out_valid, 1);
    check("t2_data_b", out_data, 147456);
    check("t2_cnt_b", out_cnt, 1);
    step();
    check("t2_vld_drop", out_valid, 0);

    // Test 3: a 4-beat group with two idle cycles between beats 2 and 3.
    beat(127, -128, 1'b0);
    beat(127, -128, 1'b0);
    step();
    step();
    beat(127, -128, 1'b0);
    beat(127, -128, 1'b1);
    check("t3_vld_early0", out_valid, 0);
    step();
    check("t3_vld_early1", out_valid, 0);
    step();
    check("t3_vld", out_valid, 1);
    check("t3_data", out_data, -585216);
    check("t3_cnt", out_cnt, 4);
    step();

    // Test 4: a result held for 5 cycles by out_ready=0.
    out_ready = 1'b0;
    beat(2, 3, 1'b1);
    beat(-1, 7, 1'b1);
    step();
    set_ab(5, 5);
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready_stall", in_ready, 0);
      check("t4_vld_stall", out_valid, 1);
      check("t4_data_stall", out_data, 54);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("t4_in_ready_release", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t4_vld_b", out_valid, 1);
    check("t4_data_b", out_data, -63);
    step();
    check("t4_vld_gap", out_valid, 0);
    step();
    check("t4_vld_c", out_valid, 1);
    check("t4_data_c", out_data, 225);
    check("t4_cnt_c", out_cnt, 1);
    step();

    // Test 5: ACC_W=20, 4 beats a=b=-128, overflowing the accumulator.
    set_ab(-128, -128);
    in_last    = 1'b0;
    in_valid20 = 1'b1;
    step();
    step();
    step();
    in_last = 1'b1;
    step();
    in_valid20 = 1'b0;
    step();
    step();
    check("t5_in_ready20", in_ready20, 1);
    check("t5_vld20", out_valid20, 1);
`ifdef ACC_SAT_EN
    check("t5_data20", out_data20, 524287);
`else
    check("t5_data20", out_data20, -458752);
`endif
    check("t5_cnt20", out_cnt20, 4);
    step();

    // Test 6: a reset mid-group throws away the partial sum.
    beat(4, 4, 1'b0);
    beat(4, 4, 1'b0);
    reset = 1'b0;
    #1;
    check("t6_rst_vld", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_cnt", out_cnt, 0);
    step();
    reset = 1'b1;
    step();
    beat(1, 1, 1'b1);
    step();
    check("t6_vld_early", out_valid, 0);
    step();
    check("t6_vld", out_valid, 1);
    check("t6_data", out_data, 9);
    check("t6_cnt", out_cnt, 1);
    step();

    // Sweep: every (a,b) pair as a single-beat group, at full rate.
    for (int a = -128; a < 128; a++) begin
      for (int b = -128; b < 128; b++) begin
        q.push_back(9 * a * b);
        beat(a, b, 1'b1);
        if (q.size() == 3) begin
          e = q.pop_front();
          check("sweep_vld", out_valid, 1);
          check("sweep_data", out_data, e);
        end
      end
    end
    repeat (2) begin
      step();
      e = q.pop_front();
      check("sweep_vld", out_valid, 1);
      check("sweep_data", out_data, e);
    end
    step();
    check("sweep_end_vld", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
